song_play_ctrl: RTL
===================

SONG_PLAY_CTRL -- requirements
Module: song_play_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- ADDR_W, 15, sample ROM address width.
- DATA_W, 4, sample width.
- TICK_DIV, 1563, clk50Mghz cycles per sample period; legal range ≥2.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk50Mghz, in, 1, sole clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request to begin playback.
- stop, in, 1, one-cycle request to abort playback.
- pause, in, 1, level; holds playback while high.
- loop_en, in, 1, level; wrap to start_addr at the end of the segment.
- start_addr, in, ADDR_W, first segment address, sampled on an accepted start.
- end_addr, in, ADDR_W, last segment address (inclusive), sampled on an accepted start.
- rom_addr, out, ADDR_W, registered address to the combinational sample ROM.
- rom_data, in, DATA_W, ROM output for rom_addr.
- sample_out, out, DATA_W, registered sample to the DAC.
- sample_valid, out, 1, one-cycle pulse when sample_out updates.
- busy, out, 1, high in PLAY or PAUSE.
- done, out, 1, one-cycle pulse at non-looping segment end.
- err, out, 1, one-cycle pulse on a rejected start.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, PLAY, PAUSE and DONE, and all outputs SHALL be registered.
REQ-004 In IDLE or DONE, start with start_addr ≤ end_addr SHALL latch both bounds, set rom_addr=start_addr, clear the tick counter and enter PLAY on the same edge.
REQ-005 In IDLE or DONE, start with start_addr > end_addr SHALL pulse err for one cycle and leave the state, rom_addr and sample_out unchanged.
REQ-006 start SHALL be ignored in PLAY and PAUSE.
REQ-007 The tick counter SHALL count 0..TICK_DIV-1 only in PLAY, hold its value in PAUSE, and wrap to 0 after TICK_DIV-1.
REQ-008 When the counter equals TICK_DIV-1 in PLAY, the next edge SHALL load sample_out with rom_data and assert sample_valid for that one cycle.
REQ-009 The first sample_valid SHALL occur TICK_DIV cycles after the edge that accepted start.
REQ-010 On each tick with rom_addr < end_addr, rom_addr SHALL increment by 1.
REQ-011 On a tick with rom_addr == end_addr and loop_en=1, rom_addr SHALL reload the latched start_addr and PLAY SHALL continue.
REQ-012 On a tick with rom_addr == end_addr and loop_en=0, the block SHALL enter DONE, pulse done with the final sample_valid, and hold rom_addr and sample_out.
REQ-013 start_addr == end_addr SHALL be legal and produce one sample per pass.
REQ-014 PLAY with pause=1 SHALL enter PAUSE on the next edge, and no tick SHALL occur in PAUSE.
REQ-015 PAUSE with pause=0 SHALL return to PLAY and resume from the held counter value.
REQ-016 stop in any state SHALL, on the next edge, enter IDLE, set rom_addr=0, sample_out=0 and clear the counter.
REQ-017 stop SHALL take priority over start, pause and a coincident tick; that tick SHALL produce no sample_valid.
REQ-018 busy SHALL equal (state==PLAY || state==PAUSE).
REQ-019 All address arithmetic SHALL be ADDR_W bits wide and SHALL never pass end_addr.

Reset
REQ-020 Asserting reset_n low SHALL asynchronously force IDLE, rom_addr=0, sample_out=0, counter=0, latched bounds=0, and sample_valid, done, err and busy all 0.
REQ-021 Reset asserted mid-playback SHALL abort the segment with no done pulse.
REQ-022 After reset_n deasserts, the block SHALL require a new start to play.

Configuration
REQ-023 With macro SONG_PLAY_CTRL_MUTE_ON_PAUSE_EN defined, sample_out SHALL read 0 while in PAUSE and show the held sample again on return to PLAY.
REQ-024 Without SONG_PLAY_CTRL_MUTE_ON_PAUSE_EN, sample_out SHALL hold its last value through PAUSE.

Verification
REQ-025 The bench SHALL cover these directed scenarios (TICK_DIV=4):
- start with bounds 10..12, loop_en=0 -> sample_valid at cycles +4, +8, +12; rom_addr 10→11→12; done coincides with the third valid; state DONE.
- Same run with loop_en=1 -> after address 12, rom_addr=10; no done; continuous valid every 4 cycles.
- pause high for 7 cycles at counter=2 -> no valid during pause; the next valid occurs 2 cycles after pause falls; the mute macro zeroes sample_out during the pause.
- start with start_addr=20, end_addr=5 -> err pulse; state IDLE; rom_addr unchanged.
- stop coincident with a tick, and separately with start -> no valid; IDLE; rom_addr=0, sample_out=0.
- reset_n low mid-segment at rom_addr=25000 (bounds 0..25195) -> immediate IDLE and zeroed outputs; no done.

Source files
------------

// File: rtl/song_play_ctrl.sv
// Sample-playback sequencer: walks a sample ROM address range, one sample every TICK_DIV clocks.
// Optional feature: define SONG_PLAY_CTRL_MUTE_ON_PAUSE_EN to drive sample_out to 0 while paused.
module song_play_ctrl #(
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned TICK_DIV = 1563
) (
    input  logic              clk50Mghz,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              tick_c;

    assign tick_c = (state_q == S_PLAY) && (cnt_q == CNT_LAST);

    // Next-state and output decode; stop overrides everything, including a coincident tick.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        start_d = start_q;
        end_d   = end_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (stop) begin
            state_d = S_IDLE;
            addr_d  = '0;
            hold_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (start_addr <= end_addr) begin
                            start_d = start_addr;
                            end_d   = end_addr;
                            addr_d  = start_addr;
                            cnt_d   = '0;
                            state_d = S_PLAY;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (pause) begin
                        state_d = S_PAUSE;
                    end
                    if (tick_c) begin
                        cnt_d   = '0;
                        hold_d  = rom_data;
                        valid_d = 1'b1;
                        if (addr_q < end_q) begin
                            addr_d = addr_q + ADDR_W'(1);
                        end else if (loop_en) begin
                            addr_d = start_q;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (!pause) begin
                        state_d = S_PLAY;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d == S_PLAY) || (state_d == S_PAUSE);
    end

    // The held sample survives a pause; only the visible copy may be muted.
`ifdef SONG_PLAY_CTRL_MUTE_ON_PAUSE_EN
    assign out_d = (state_d == S_PAUSE) ? '0 : hold_d;
`else
    assign out_d = hold_d;
`endif

    always_ff @(posedge clk50Mghz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            start_q <= '0;
            end_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            start_q <= start_d;
            end_q   <= end_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign rom_addr     = addr_q;
    assign sample_out   = out_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule
